// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction-cache refill controller.
// Contents:
//   refill_state_t : refill FSM states (IDLE, FETCH, FILL, DRAIN)
//   LINE_WORDS     : 32-bit words per cache line
//   OFFSET_BITS    : byte-offset bits inside one line
//   line_t         : one packed cache line, word i at bits [i*32 +: 32]
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FILL  = 2'd2,
    DRAIN = 2'd3
  } refill_state_t;

  localparam int LINE_WORDS  = 4;
  localparam int OFFSET_BITS = 4;

  typedef logic [LINE_WORDS*32-1:0] line_t;

endpackage

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache line refill controller.
// On a miss it reads the four words of the missing line from main memory
// one at a time, assembles them into a line buffer and strobes the full
// line into the cache for one cycle. Memory requests can be abandoned by a
// pipeline flush; an outstanding request is drained before returning idle.
//
// Optional feature macro: ICACHE_CRITICAL_WORD_FIRST_EN
//   Fetch starts at the requested word and wraps; the critical word is
//   bypassed on crit_word/crit_valid and the stall is released early while
//   the PC stays inside the line being filled.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   addr         in   fetch PC
//   hit          in   cache hit for addr
//   flush        in   pipeline redirect, abandons the pending refill
//   mem_req      out  word read request to memory
//   mem_addr     out  word-aligned read address
//   mem_ready    in   mem_rdata valid for the current request
//   mem_rdata    in   returned word
//   fetch_data   out  assembled line
//   fetch_enable out  one-cycle line write strobe
//   stall        out  freeze of PC / fetch stage
//   crit_word    out  bypassed critical word (feature macro only)
//   crit_valid   out  crit_word valid strobe (feature macro only)
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BLOCK_SIZE = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic                             hit,
  input  logic                             flush,
  output logic                             mem_req,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  input  logic                             mem_ready,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] fetch_data,
  output logic                             fetch_enable,
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  output logic [31:0]                      crit_word,
  output logic                             crit_valid,
`endif
  output logic                             stall
);

  refill_state_t state_reg;
  logic [1:0]    cnt_reg;
  logic [1:0]    start_reg;
  logic [27:0]   line_addr_reg;
  line_t         line_reg;
  logic          mem_req_reg;
  logic [31:0]   mem_addr_reg;
  logic          fetch_enable_reg;

  logic [1:0] cnt_next;
  logic [1:0] start_idx;
  logic       idle_miss;

  assign cnt_next  = cnt_reg + 2'd1;
  assign idle_miss = (state_reg == IDLE) && !hit && !flush;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  logic crit_seen_reg;
  logic crit_accept;
  logic in_line;
  assign start_idx   = addr[3:2];
  assign crit_accept = (state_reg == FETCH) && mem_ready && !flush && (cnt_reg == start_reg);
  assign in_line     = (addr[31:4] == line_addr_reg);
  assign crit_word   = mem_rdata;
  assign crit_valid  = rst_n && crit_accept;
  // Once the critical word is in hand the pipeline may run, but only while it
  // keeps fetching from the line under refill; leaving it re-stalls.
  assign stall = rst_n && (idle_miss ||
                 ((state_reg != IDLE) &&
                  !((crit_seen_reg || crit_accept) && in_line && (state_reg != DRAIN))));
`else
  logic unused_offset;
  assign unused_offset = ^addr[3:0];
  assign start_idx     = 2'b00;
  assign stall         = rst_n && (idle_miss || (state_reg != IDLE));
`endif

  // Registered outputs are also masked while reset is held so nothing leaks
  // out during the reset cycle itself.
  assign mem_req      = rst_n && mem_req_reg;
  assign mem_addr     = rst_n ? mem_addr_reg : '0;
  assign fetch_enable = rst_n && fetch_enable_reg;
  assign fetch_data   = line_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      cnt_reg          <= 2'd0;
      start_reg        <= 2'd0;
      line_addr_reg    <= '0;
      line_reg         <= '0;
      mem_req_reg      <= 1'b0;
      mem_addr_reg     <= '0;
      fetch_enable_reg <= 1'b0;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
      crit_seen_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          fetch_enable_reg <= 1'b0;
          if (idle_miss) begin
            line_addr_reg <= addr[31:4];
            cnt_reg       <= start_idx;
            start_reg     <= start_idx;
            mem_req_reg   <= 1'b1;
            mem_addr_reg  <= {addr[31:4], start_idx, 2'b00};
            state_reg     <= FETCH;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
            crit_seen_reg <= 1'b0;
`endif
          end
        end
        FETCH: begin
          if (mem_ready) begin
            if (flush) begin
              // The returning word belongs to an abandoned line: drop it.
              mem_req_reg <= 1'b0;
              state_reg   <= IDLE;
            end else begin
              line_reg[{cnt_reg, 5'd0} +: 32] <= mem_rdata;
              cnt_reg <= cnt_next;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
              crit_seen_reg <= 1'b1;
`endif
              // Wrapping back to the start index means all four words are in.
              if (cnt_next == start_reg) begin
                mem_req_reg      <= 1'b0;
                fetch_enable_reg <= 1'b1;
                state_reg        <= FILL;
              end else begin
                mem_addr_reg <= {line_addr_reg, cnt_next, 2'b00};
              end
            end
          end else if (flush) begin
            // Request is already in flight; keep it asserted until memory answers.
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (mem_ready) begin
            mem_req_reg <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        FILL: begin
          fetch_enable_reg <= 1'b0;
          state_reg        <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
